w1_acc9: RTL and testbench
==========================

W1_ACC9 -- requirements
Module: w1_acc9

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: i_valid  input  1  i_w1 carries a sample this cycle.
REQ-004 SHALL have port: i_w1  input  10  unsigned weighted product from the upstream constant-multiplier stage.
REQ-005 SHALL have port: i_clr  input  1  synchronous abort of the current window.
REQ-006 SHALL have port: o_sum  output  14  unsigned sum of the last completed 9-sample window.
REQ-007 SHALL have port: o_valid  output  1  one-cycle pulse, o_sum updated this cycle.
REQ-008 SHALL have port: o_cnt  output  4  samples accepted in the current window, 0..8.
REQ-009 SHALL have parameter: WIN, default 9, samples per window; legal range 2..9 with fixed 14-bit o_sum.

Function
REQ-010 SHALL accept a sample on every rising clk edge where i_valid=1 and i_clr=0; there is no backpressure.
REQ-011 SHALL keep a 14-bit accumulator acc and a 4-bit counter cnt.
REQ-012 SHALL zero-extend i_w1 to 14 bits before adding; the maximum total is 9*1023=9207, so no overflow or saturation is possible.
REQ-013 SHALL run a state machine with two states: ACC (cnt<WIN-1) and LAST (cnt=WIN-1).
REQ-014 On an accepted sample in ACC, SHALL set acc<=acc+i_w1 and cnt<=cnt+1; the next state is LAST when the new cnt equals WIN-1.
REQ-015 On an accepted sample in LAST, SHALL set o_sum<=acc+i_w1 and o_valid<=1 for the next cycle only, set acc<=0 and cnt<=0, and return to ACC.
REQ-016 Latency SHALL be one cycle: o_valid rises on the clk edge that captures the WIN-th sample.
REQ-017 SHALL hold o_sum stable between o_valid pulses.
REQ-018 o_valid SHALL be 0 in every cycle except those defined by REQ-015.
REQ-019 SHALL accept a sample arriving in the same cycle o_valid=1 as sample 1 of the next window; back-to-back windows carry no bubble.
REQ-020 With i_valid=0 and i_clr=0, SHALL hold acc, cnt and state unchanged; gaps between samples are allowed.
REQ-021 i_clr=1 SHALL set acc<=0, cnt<=0 and state<=ACC on the next edge, without changing o_sum and without raising o_valid.
REQ-022 With i_clr=1 and i_valid=1 together, i_clr SHALL win and the sample SHALL be discarded, including in LAST.
REQ-023 o_cnt SHALL equal cnt at all times.

Reset
REQ-024 While rst=1, asynchronously and regardless of clk, SHALL hold acc=0, cnt=0, state=ACC, o_sum=0 and o_valid=0.
REQ-025 After rst deasserts, the first edge with i_valid=1 SHALL be accepted as sample 1.
REQ-026 rst asserted mid-window SHALL discard the partial sum and produce no o_valid.

Verification
REQ-027 Scenario: rst pulse, then 9 consecutive samples i_w1=1023 -> one cycle later o_valid=1, o_sum=9207; o_cnt sequence 1..8 then 0.
REQ-028 Scenario: samples 1,2,...,9 with one-cycle i_valid gaps between them -> a single o_valid pulse with o_sum=45; o_valid=0 in every gap cycle.
REQ-029 Scenario: 18 back-to-back samples, window A all 7, window B all 63 -> o_valid pulses exactly 9 cycles apart with o_sum=63 then 567.
REQ-030 Scenario: 5 samples of 100, then i_clr=1 with i_valid=1 and i_w1=500, then 9 samples of 10 -> no pulse after the first 5 samples, then o_sum=90; the previous o_sum is held throughout.
REQ-031 Scenario: rst asserted asynchronously between edges after 8 samples, then released and 9 samples of 2 fed -> o_sum, o_cnt and o_valid read 0 immediately on assertion; the next pulse gives o_sum=18.
REQ-032 Scenario: WIN=2 build with samples 1023, 0, 5, 5 -> o_sum=1023 then 10.

Source files
------------

// File: rtl/w1_acc9.sv
// Sums WIN consecutive accepted i_w1 samples into o_sum; 1-cycle latency, o_valid pulses on the edge capturing sample WIN.
// No backpressure: every i_valid cycle is consumed; i_clr aborts the open window and wins over i_valid.
module w1_acc9 #(
   parameter int WIN = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [9:0]  i_w1,
   input  logic        i_clr,
   output logic [13:0] o_sum,
   output logic        o_valid,
   output logic [3:0]  o_cnt
);

   typedef enum logic {ACC, LAST} state_t;

   localparam logic [3:0] LAST_CNT = 4'(WIN - 1);

   state_t      state, state_nxt;
   logic [13:0] acc, acc_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [13:0] sum_nxt;
   logic        vld_nxt;
   logic [13:0] add_res;

   assign add_res = acc + {4'b0000, i_w1};
   assign o_cnt   = cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ACC;
         acc     <= '0;
         cnt     <= '0;
         o_sum   <= '0;
         o_valid <= 1'b0;
      end else begin
         state   <= state_nxt;
         acc     <= acc_nxt;
         cnt     <= cnt_nxt;
         o_sum   <= sum_nxt;
         o_valid <= vld_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      sum_nxt   = o_sum;
      vld_nxt   = 1'b0;
      if (i_clr) begin
         // Abort drops any sample offered alongside it, even the closing one.
         state_nxt = ACC;
         acc_nxt   = '0;
         cnt_nxt   = '0;
      end else if (i_valid) begin
         case (state)
            ACC: begin
               acc_nxt = add_res;
               cnt_nxt = cnt + 4'd1;
               if (cnt + 4'd1 == LAST_CNT) state_nxt = LAST;
            end
            LAST: begin
               sum_nxt   = add_res;
               vld_nxt   = 1'b1;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = ACC;
            end
            default: state_nxt = ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_w1_acc9.sv
// Directed and random checks of w1_acc9 at WIN=9 and WIN=2 against a running-sum window model.
module tb_w1_acc9;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_valid = 1'b0;
   logic [9:0]  i_w1 = '0;
   logic        i_clr = 1'b0;
   logic [13:0] sum_a, sum_b;
   logic        vld_a, vld_b;
   logic [3:0]  cnt_a, cnt_b;

   int checks = 0;
   int errors = 0;

   int m_acc[2];
   int m_n[2];
   int m_out[2];
   int m_vld[2];
   int m_win[2] = '{9, 2};

   always #5 clk = ~clk;

   w1_acc9 #(.WIN(9)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_w1(i_w1), .i_clr(i_clr),
      .o_sum(sum_a), .o_valid(vld_a), .o_cnt(cnt_a)
   );

   w1_acc9 #(.WIN(2)) dut2 (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_w1(i_w1), .i_clr(i_clr),
      .o_sum(sum_b), .o_valid(vld_b), .o_cnt(cnt_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_acc[k] = 0;
         m_n[k]   = 0;
         m_out[k] = 0;
         m_vld[k] = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, " win9 o_valid"}, 32'(vld_a), 32'(m_vld[0]));
      chk({tag, " win9 o_sum"},   32'(sum_a), 32'(m_out[0]));
      chk({tag, " win9 o_cnt"},   32'(cnt_a), 32'(m_n[0]));
      chk({tag, " win2 o_valid"}, 32'(vld_b), 32'(m_vld[1]));
      chk({tag, " win2 o_sum"},   32'(sum_b), 32'(m_out[1]));
      chk({tag, " win2 o_cnt"},   32'(cnt_b), 32'(m_n[1]));
   endtask

   // One clock of stimulus; the model tracks what each window has gathered so far.
   task automatic step(input string tag, input logic v, input int w, input logic c);
      i_valid = v;
      i_w1    = 10'(w);
      i_clr   = c;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         m_vld[k] = 0;
         if (c) begin
            m_acc[k] = 0;
            m_n[k]   = 0;
         end else if (v) begin
            m_acc[k] += w;
            m_n[k]++;
            if (m_n[k] == m_win[k]) begin
               m_out[k] = m_acc[k];
               m_vld[k] = 1;
               m_acc[k] = 0;
               m_n[k]   = 0;
            end
         end
      end
      check_all(tag);
      i_valid = 1'b0;
      i_clr   = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      check_all("por");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Full-scale window: 9 x 1023 = 9207, cnt walks 1..8 then 0.
      pulse_reset();
      for (int i = 0; i < 9; i++) step("max", 1'b1, 1023, 1'b0);
      step("max_idle", 1'b0, 0, 1'b0);

      // Samples 1..9 with idle gaps between them.
      pulse_reset();
      for (int i = 1; i <= 9; i++) begin
         step("gap_smp", 1'b1, i, 1'b0);
         step("gap_idle", 1'b0, 777, 1'b0);
      end

      // Back-to-back windows: 9 x 7 then 9 x 63.
      pulse_reset();
      for (int i = 0; i < 9; i++) step("b2b_a", 1'b1, 7, 1'b0);
      for (int i = 0; i < 9; i++) step("b2b_b", 1'b1, 63, 1'b0);

      // Clear with a valid sample: sample dropped, o_sum held.
      for (int i = 0; i < 5; i++) step("clr_pre", 1'b1, 100, 1'b0);
      step("clr", 1'b1, 500, 1'b1);
      for (int i = 0; i < 9; i++) step("clr_post", 1'b1, 10, 1'b0);

      // Clear arriving while the WIN=9 instance waits for its last sample.
      for (int i = 0; i < 8; i++) step("clr_last_pre", 1'b1, 3, 1'b0);
      step("clr_last", 1'b1, 3, 1'b1);
      step("clr_last_idle", 1'b0, 0, 1'b0);

      // Asynchronous reset between edges after 8 samples.
      for (int i = 0; i < 8; i++) step("arst_pre", 1'b1, 50, 1'b0);
      rst = 1'b1;
      model_reset();
      #1;
      check_all("arst_async");
      #2;
      rst = 1'b0;
      for (int i = 0; i < 9; i++) step("arst_post", 1'b1, 2, 1'b0);

      // WIN=2 instance: 1023,0 -> 1023 and 5,5 -> 10.
      pulse_reset();
      step("w2_a", 1'b1, 1023, 1'b0);
      step("w2_b", 1'b1, 0, 1'b0);
      step("w2_c", 1'b1, 5, 1'b0);
      step("w2_d", 1'b1, 5, 1'b0);

      // Random traffic with idles and occasional clears.
      pulse_reset();
      for (int i = 0; i < 400; i++) begin
         step("rand",
              1'($urandom_range(0, 9) < 7),
              int'($urandom_range(0, 1023)),
              1'($urandom_range(0, 19) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
